// File: rtl/lc3_pkg.sv
// Shared types and defaults for the LC-3 memory sequencer.
package lc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// CPU request/response and memory bus bundle; slave = controller, master = CPU/memory side.
interface lc3_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_mdr_we;
    logic              resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_r;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_r,
        output req_ready, resp_valid, resp_rdata, resp_mdr_we, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_r,
        input  req_ready, resp_valid, resp_rdata, resp_mdr_we, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lc3_wait_counter.sv
// 8-bit saturating ACCESS-cycle counter; expired flags the LIMIT-th counted cycle.
module lc3_wait_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] count,
    output logic       expired
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // count holds the cycles already spent, so the LIMIT-th cycle sees LIMIT-1
    assign expired = (count >= 8'(LIMIT - 1));
endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access sequencer between MAR/MDR and a ready-handshaked memory bus.
// Optional abort on a stalled access: define LC3_MEM_TIMEOUT_EN.
module lc3_mem_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    lc3_mem_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
    localparam logic [1:0] ST_RESP   = 2'(RESP);

    logic [1:0]        state_q, state_d;
    logic              accept_c, done_c, timeout_c;
    logic              we_q;
    logic              req_ready_q, resp_valid_q, resp_mdr_we_q, resp_err_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, resp_rdata_q;
`ifdef LC3_MEM_TIMEOUT_EN
    logic              cnt_expired;
`endif

    lc3_wait_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ST_IDLE),
        .inc     (state_q == ST_ACCESS),
        .count   (),
`ifdef LC3_MEM_TIMEOUT_EN
        .expired (cnt_expired)
`else
        .expired ()
`endif
    );

    // Next-state decode; a ready seen on the expiry cycle still completes normally
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_r) begin
                    done_c  = 1'b1;
                    state_d = ST_RESP;
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (cnt_expired) begin
                    timeout_c = 1'b1;
                    state_d   = ST_RESP;
                end
`endif
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            we_q          <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_mdr_we_q <= 1'b0;
            resp_err_q    <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            resp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= (state_d == ST_IDLE);
            resp_valid_q  <= (state_d == ST_RESP);
            resp_mdr_we_q <= done_c & ~we_q;
            resp_err_q    <= timeout_c;
            mem_en_q      <= (state_d == ST_ACCESS);
            mem_we_q      <= (state_d == ST_ACCESS) & (accept_c ? bus.req_we : we_q);
            if (accept_c) begin
                we_q        <= bus.req_we;
                mem_addr_q  <= bus.req_addr;
                mem_wdata_q <= bus.req_wdata;
            end
            if (done_c && !we_q) begin
                resp_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_mdr_we = resp_mdr_we_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: vector table plus hand-written corner sequences.
module tb_lc3_mem_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lc3_mem_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    lc3_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        mr;
        logic [15:0] mrdata;
        logic        e_ready;
        logic        e_en;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_valid;
        logic        e_mdr;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [15:0] a,
                         input logic [15:0] wd, input logic r, input logic [15:0] rd);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.mem_r     = r;
        bus.mem_rdata = rd;
    endtask

    initial begin
        int  n;
        logic saw_valid;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // reset / idle state
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_en",    32'(bus.mem_en),    32'd0);
        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", 32'(bus.resp_rdata), 32'h0);
        chk("rst_err",   32'(bus.resp_err),   32'd0);

        //          v  we  addr     wdata    mr rdata    rdy en we  addr     wdata    vld mdr rdata
        vecs[0] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000};
        vecs[1] = '{1'b1,1'b0,16'h3000,16'h0000,1'b1,16'h1234, 1'b0,1'b1,1'b0,16'h3000,16'h0000,1'b0,1'b0,16'h0000};
        vecs[2] = '{1'b0,1'b0,16'h0000,16'h0000,1'b1,16'h1234, 1'b0,1'b0,1'b0,16'h3000,16'h0000,1'b1,1'b1,16'h1234};
        vecs[3] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b0,16'h3000,16'h0000,1'b0,1'b0,16'h1234};
        vecs[4] = '{1'b1,1'b1,16'hFE06,16'h0041,1'b1,16'hDEAD, 1'b0,1'b1,1'b1,16'hFE06,16'h0041,1'b0,1'b0,16'h1234};
        vecs[5] = '{1'b0,1'b0,16'h1111,16'h2222,1'b0,16'h0000, 1'b0,1'b1,1'b1,16'hFE06,16'h0041,1'b0,1'b0,16'h1234};
        vecs[6] = '{1'b0,1'b0,16'h1111,16'h2222,1'b0,16'h0000, 1'b0,1'b1,1'b1,16'hFE06,16'h0041,1'b0,1'b0,16'h1234};
        vecs[7] = '{1'b0,1'b0,16'h1111,16'h2222,1'b0,16'h0000, 1'b0,1'b1,1'b1,16'hFE06,16'h0041,1'b0,1'b0,16'h1234};
        vecs[8] = '{1'b0,1'b0,16'h1111,16'h2222,1'b1,16'hBEEF, 1'b0,1'b0,1'b0,16'hFE06,16'h0041,1'b1,1'b0,16'h1234};
        vecs[9] = '{1'b0,1'b0,16'h0000,16'h0000,1'b0,16'h0000, 1'b1,1'b0,1'b0,16'hFE06,16'h0041,1'b0,1'b0,16'h1234};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mr, vecs[i].mrdata);
            tick();
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready),   32'(vecs[i].e_ready));
            chk($sformatf("v%0d_en", i),    32'(bus.mem_en),      32'(vecs[i].e_en));
            chk($sformatf("v%0d_we", i),    32'(bus.mem_we),      32'(vecs[i].e_we));
            chk($sformatf("v%0d_addr", i),  32'(bus.mem_addr),    32'(vecs[i].e_addr));
            chk($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata),   32'(vecs[i].e_wdata));
            chk($sformatf("v%0d_valid", i), 32'(bus.resp_valid),  32'(vecs[i].e_valid));
            chk($sformatf("v%0d_mdr", i),   32'(bus.resp_mdr_we), 32'(vecs[i].e_mdr));
            chk($sformatf("v%0d_rdata", i), 32'(bus.resp_rdata),  32'(vecs[i].e_rdata));
            chk($sformatf("v%0d_err", i),   32'(bus.resp_err),    32'd0);
        end

        // req_valid held through ACCESS/RESP with a changing address
        drive(1'b1, 1'b0, 16'h1111, 16'h0, 1'b0, 16'h0);
        tick();
        chk("hold_c1_ready", 32'(bus.req_ready), 32'd0);
        chk("hold_c1_addr",  32'(bus.mem_addr),  32'h1111);
        bus.req_addr = 16'h2222;
        tick();
        chk("hold_c2_ready", 32'(bus.req_ready), 32'd0);
        chk("hold_c2_en",    32'(bus.mem_en),    32'd1);
        chk("hold_c2_addr",  32'(bus.mem_addr),  32'h1111);
        bus.mem_r = 1'b1;
        bus.mem_rdata = 16'h0BAD;
        tick();
        chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("hold_resp_ready", 32'(bus.req_ready),  32'd0);
        chk("hold_resp_rdata", 32'(bus.resp_rdata), 32'h0BAD);
        bus.mem_r = 1'b0;
        tick();
        chk("hold_idle_ready", 32'(bus.req_ready), 32'd1);
        chk("hold_idle_en",    32'(bus.mem_en),    32'd0);
        tick();
        chk("hold_2nd_en",   32'(bus.mem_en),   32'd1);
        chk("hold_2nd_addr", 32'(bus.mem_addr), 32'h2222);
        drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0C0D);
        tick();
        chk("hold_2nd_valid", 32'(bus.resp_valid), 32'd1);
        chk("hold_2nd_rdata", 32'(bus.resp_rdata), 32'h0C0D);
        bus.mem_r = 1'b0;
        tick();

        // reset in the second ACCESS cycle aborts with no response
        drive(1'b1, 1'b0, 16'h4000, 16'h0, 1'b0, 16'h0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("rstmid_c2_en", 32'(bus.mem_en), 32'd1);
        rst = 1'b1;
        bus.mem_r = 1'b1;
        bus.mem_rdata = 16'h9999;
        tick();
        rst = 1'b0;
        bus.mem_r = 1'b0;
        chk("rstmid_ready", 32'(bus.req_ready),  32'd1);
        chk("rstmid_en",    32'(bus.mem_en),     32'd0);
        chk("rstmid_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstmid_addr",  32'(bus.mem_addr),   32'h0);
        chk("rstmid_rdata", 32'(bus.resp_rdata), 32'h0);
        saw_valid = 1'b0;
        repeat (4) begin
            tick();
            if (bus.resp_valid) saw_valid = 1'b1;
        end
        chk("rstmid_no_resp", 32'(saw_valid), 32'd0);
        drive(1'b1, 1'b0, 16'h4001, 16'h0, 1'b1, 16'hA5A5);
        tick();
        chk("rstmid_re_addr", 32'(bus.mem_addr), 32'h4001);
        bus.req_valid = 1'b0;
        tick();
        chk("rstmid_re_valid", 32'(bus.resp_valid),  32'd1);
        chk("rstmid_re_mdr",   32'(bus.resp_mdr_we), 32'd1);
        chk("rstmid_re_rdata", 32'(bus.resp_rdata),  32'hA5A5);
        bus.mem_r = 1'b0;
        tick();

`ifdef LC3_MEM_TIMEOUT_EN
        // timeout after 8 ACCESS cycles with no ready
        drive(1'b1, 1'b0, 16'h5000, 16'h0, 1'b0, 16'h1357);
        tick();
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.mem_en && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n),                32'd8);
        chk("to_valid",  32'(bus.resp_valid),   32'd1);
        chk("to_err",    32'(bus.resp_err),     32'd1);
        chk("to_mdr",    32'(bus.resp_mdr_we),  32'd0);
        chk("to_rdata",  32'(bus.resp_rdata),   32'hA5A5);
        tick();
        chk("to_err_clr", 32'(bus.resp_err), 32'd0);
        // ready on the expiry cycle completes normally
        drive(1'b1, 1'b0, 16'h5001, 16'h0, 1'b0, 16'h0);
        tick();
        bus.req_valid = 1'b0;
        repeat (7) tick();
        chk("to_edge_en", 32'(bus.mem_en), 32'd1);
        bus.mem_r = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        chk("to_edge_valid", 32'(bus.resp_valid),  32'd1);
        chk("to_edge_err",   32'(bus.resp_err),    32'd0);
        chk("to_edge_mdr",   32'(bus.resp_mdr_we), 32'd1);
        chk("to_edge_rdata", 32'(bus.resp_rdata),  32'h7777);
        bus.mem_r = 1'b0;
        tick();
`else
        // without the timeout, a stalled access waits indefinitely
        drive(1'b1, 1'b1, 16'h6000, 16'h0055, 1'b0, 16'h0);
        tick();
        bus.req_valid = 1'b0;
        saw_valid = 1'b0;
        n = 0;
        repeat (30) begin
            tick();
            n++;
            if (bus.resp_valid) saw_valid = 1'b1;
        end
        chk("stall_en",      32'(bus.mem_en), 32'd1);
        chk("stall_no_resp", 32'(saw_valid),  32'd0);
        bus.mem_r = 1'b1;
        tick();
        chk("stall_valid", 32'(bus.resp_valid),  32'd1);
        chk("stall_err",   32'(bus.resp_err),    32'd0);
        chk("stall_mdr",   32'(bus.resp_mdr_we), 32'd0);
        chk("stall_rdata", 32'(bus.resp_rdata),  32'hA5A5);
        bus.mem_r = 1'b0;
        tick();
`endif
        chk("end_ready", 32'(bus.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
